// File: rtl/spi_reader_arb.sv
// Arbiter sharing one spi_flash_reader command/data channel among N_REQ requesters.
// Optional macro SPI_ARB_FIXED_PRIO_EN: fixed priority (requester 0 highest) instead of round-robin.
module spi_reader_arb #(
    parameter int N_REQ = 2,
    parameter int AW    = 24,
    parameter int LW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*LW-1:0] req_len,
    input  logic [N_REQ-1:0]    req_go,
    output logic [N_REQ-1:0]    req_rdy,
    output logic [7:0]          req_data,
    output logic [N_REQ-1:0]    req_valid,
    output logic [AW-1:0]       sr_addr,
    output logic [LW-1:0]       sr_len,
    output logic                sr_go,
    input  logic                sr_rdy,
    input  logic [7:0]          sr_data,
    input  logic                sr_valid
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, XFER} state_t;

    state_t         state_reg, state_next;
    logic [GW-1:0]  grant_reg, grant_next, pick;
    logic [N_REQ-1:0] pending_vec;
    logic [AW-1:0]  slot_addr [N_REQ];
    logic [LW-1:0]  slot_len  [N_REQ];
    logic           busy, load_cmd, issue_fire, route;
    logic [AW-1:0]  sr_addr_reg;
    logic [LW-1:0]  sr_len_reg;
    logic [7:0]     req_data_reg;
    logic [N_REQ-1:0] req_valid_reg;

    assign busy       = (state_reg != IDLE);
    assign issue_fire = (state_reg == ISSUE) && sr_rdy;
    // Bytes arriving before the reader drops rdy still belong to the granted transfer.
    assign route      = sr_valid && ((state_reg == WAIT_START) || (state_reg == XFER));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        logic          pending_reg;
        logic [AW-1:0] addr_reg;
        logic [LW-1:0] len_reg;
        logic          accept;

        assign accept = req_go[gi] && req_rdy[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_reg <= 1'b0;
                addr_reg    <= '0;
                len_reg     <= '0;
            end else if (accept) begin
                pending_reg <= 1'b1;
                addr_reg    <= req_addr[gi*AW +: AW];
                len_reg     <= req_len[gi*LW +: LW];
            end else if (issue_fire && (grant_reg == GW'(gi))) begin
                pending_reg <= 1'b0;
            end
        end

        assign pending_vec[gi] = pending_reg;
        assign slot_addr[gi]   = addr_reg;
        assign slot_len[gi]    = len_reg;
        assign req_rdy[gi]     = ~pending_reg & ~(busy && (grant_reg == GW'(gi)));
    end

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pending_vec[k]) pick = GW'(k);
        end
    end
`else
    logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GW:0]   idx;
    logic          found;

    // First pending slot at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr_reg} + (GW+1)'(k);
            if (idx >= (GW+1)'(N_REQ)) idx = idx - (GW+1)'(N_REQ);
            if (!found && pending_vec[idx[GW-1:0]]) begin
                pick  = idx[GW-1:0];
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        load_cmd   = 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
        rr_ptr_next = rr_ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|pending_vec) begin
                    grant_next = pick;
                    load_cmd   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (sr_rdy) state_next = WAIT_START;
            end
            WAIT_START: begin
                if (!sr_rdy) state_next = XFER;
            end
            XFER: begin
                if (sr_rdy) begin
                    state_next = IDLE;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    rr_ptr_next = (grant_reg == GW'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            sr_addr_reg   <= '0;
            sr_len_reg    <= '0;
            req_data_reg  <= '0;
            req_valid_reg <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_ptr_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            req_data_reg <= sr_data;
            if (load_cmd) begin
                sr_addr_reg <= slot_addr[pick];
                sr_len_reg  <= slot_len[pick];
            end
            req_valid_reg <= route ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_reg) : '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_ptr_reg   <= rr_ptr_next;
`endif
        end
    end

    assign sr_go     = issue_fire;
    assign sr_addr   = sr_addr_reg;
    assign sr_len    = sr_len_reg;
    assign req_data  = req_data_reg;
    assign req_valid = req_valid_reg;

endmodule
